// File: rtl/instruction_fetch.sv
// LEGv8 instruction fetch stage with integrated IF/ID register.
// A one-entry skid buffer holds fetched words through decode stalls; taken branches squash wrong-path fetches.
module instruction_fetch #(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              if_id_valid,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [31:0]       if_id_instr,
   output logic [10:0]       control_opcode
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 11;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} fetchState_t;

   fetchState_t        state, stateNext;
   logic [ADDR_W-1:0]  pc, pcNext;
   logic [ADDR_W-1:0]  addrNext;
   logic               reqNext;
   logic               validNext;
   logic [ADDR_W-1:0]  idPcNext;
   logic [INSTR_W-1:0] instrNext;
   logic [OP_W-1:0]    opcodeNext;
   logic [ADDR_W-1:0]  skidPc, skidPcNext;
   logic [INSTR_W-1:0] skidInstr, skidInstrNext;
   logic [ADDR_W-1:0]  targetAligned;

   assign targetAligned = branch_target & ~ADDR_W'(3);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         imem_req       <= 1'b0;
         imem_addr      <= RESET_PC;
         if_id_valid    <= 1'b0;
         if_id_pc       <= '0;
         if_id_instr    <= '0;
         control_opcode <= '0;
         skidPc         <= '0;
         skidInstr      <= '0;
      end else begin
         state          <= stateNext;
         pc             <= pcNext;
         imem_req       <= reqNext;
         imem_addr      <= addrNext;
         if_id_valid    <= validNext;
         if_id_pc       <= idPcNext;
         if_id_instr    <= instrNext;
         control_opcode <= opcodeNext;
         skidPc         <= skidPcNext;
         skidInstr      <= skidInstrNext;
      end
   end

   // Next-state, PC, skid and IF/ID update
   always_comb begin
      stateNext     = state;
      pcNext        = pc;
      validNext     = stall ? if_id_valid : 1'b0;
      idPcNext      = if_id_pc;
      instrNext     = if_id_instr;
      skidPcNext    = skidPc;
      skidInstrNext = skidInstr;

      case (state)
         IDLE: stateNext = FETCH;
         FETCH: begin
            if (imem_ready) begin
               pcNext = pc + ADDR_W'(4);
               if (stall) begin
                  skidPcNext    = pc;
                  skidInstrNext = imem_rdata;
                  stateNext     = HOLD;
               end else begin
                  validNext = 1'b1;
                  idPcNext  = pc;
                  instrNext = imem_rdata;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               validNext = 1'b1;
               idPcNext  = skidPc;
               instrNext = skidInstr;
               stateNext = FETCH;
            end
         end
         KILL: begin
            if (imem_ready) stateNext = FETCH;
         end
         default: stateNext = IDLE;
      endcase

      // Redirect overrides stall and ready; an unanswered request must drain in KILL
      if (branch_taken) begin
         pcNext    = targetAligned;
         validNext = 1'b0;
         if (state == KILL || (state == FETCH && !imem_ready)) stateNext = KILL;
         else stateNext = FETCH;
      end

      addrNext   = (stateNext == KILL) ? imem_addr : pcNext;
      reqNext    = (stateNext == FETCH) || (stateNext == KILL);
      opcodeNext = validNext ? instrNext[31:21] : '0;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage with integrated IF/ID pipeline register for the LEGv8 core. Keeps the program counter and fetches 32-bit words over a req/ready instruction-memory handshake. Holds fetched words through decode stalls with a one-entry skid buffer and squashes wrong-path fetches on taken branches. Its `control_opcode` output, instruction bits [31:21], drives the control unit's opcode input directly.

## Interface
- `ADDR_W`, 64, PC and memory address width
- `RESET_PC`, 0, first fetch address after reset (word aligned)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address; low two bits always 0
- `imem_ready`  in  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `stall`  in  1  decode cannot accept a new IF/ID entry this cycle
- `branch_taken`  in  1  one-cycle redirect pulse
- `branch_target`  in  ADDR_W  redirect address; bits [1:0] ignored, treated as 0
- `if_id_valid`  out  1  IF/ID entry holds a live instruction
- `if_id_pc`  out  ADDR_W  PC of the IF/ID instruction
- `if_id_instr`  out  32  IF/ID instruction word
- `control_opcode`  out  11  `if_id_instr[31:21]` when `if_id_valid`=1; 0 otherwise (decodes as control-unit default, all controls 0)

## Operation
- FSM states: IDLE, FETCH, HOLD, KILL.
- IDLE: entered on reset for exactly one cycle. `imem_req`=0. Next state is FETCH.
- FETCH: `imem_req`=1, `imem_addr`=pc. Address stays stable until `imem_ready`.
  - Ready with stall=0: word goes to IF/ID (valid=1, pc), pc += 4, stay in FETCH.
  - Ready with stall=1: word and pc go to the skid buffer, pc += 4, go to HOLD.
  - Not ready: stay in FETCH.
- HOLD: `imem_req`=0. IF/ID is unchanged. When stall=0, the buffer moves to IF/ID and the state returns to FETCH.
- KILL: `imem_req`=1 with the squashed address held stable. On `imem_ready` the data is dropped and the state goes to FETCH. pc already holds the target.
- IF/ID update when no word is loaded into it:
  - stall=1: holds its value.
  - stall=0: `if_id_valid` is cleared.
- branch_taken has the highest priority, above stall and ready:
  - Next edge: pc ← {branch_target[ADDR_W-1:2],2'b00}, `if_id_valid` ← 0, skid buffer invalidated.
  - From FETCH with `imem_ready`=0: go to KILL.
  - From FETCH with `imem_ready`=1: the word is dropped and the state is FETCH.
  - From HOLD or IDLE: go to FETCH.
  - From KILL: stay in KILL with the new target.
- PC arithmetic is modulo 2^ADDR_W. All-ones−3 + 4 wraps to 0.

## Timing
- Reset values: pc=RESET_PC, state IDLE, `imem_req`=0, `imem_addr`=RESET_PC, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=0, `control_opcode`=0, skid buffer empty.
- First request comes in the second cycle after `rst_n` rises.
- Fetch-to-IF/ID latency: the word is visible on `if_id_*` the cycle after `imem_ready`.
- With ready held at 1 and no stall, throughput is 1 instruction per cycle.
- Branch-to-redirect: `imem_addr`=target in the cycle after the `branch_taken` pulse, or after the KILL drain completes.
- `rst_n`=0 mid-operation, including mid-KILL or HOLD, forces reset values at the next edge. An outstanding memory response is not tracked afterwards.

## Test plan
- Reset release, `imem_ready`=1, no stall: `imem_addr` reads 0,4,8,12 on consecutive cycles. `if_id_pc` trails by one cycle. `control_opcode`=11'b11111000010 for word 0xF8400000.
- `imem_ready` low for 3 cycles at addr 0x8: `imem_req`=1 and `imem_addr`=0x8 stable all 3 cycles. `if_id_valid`=0 during the wait (stall=0).
- Word at 0x10 returns with stall=1 for 4 cycles: `imem_req`=0 during HOLD and IF/ID unchanged. On stall release, IF/ID gets pc 0x10, then fetch resumes at 0x14.
- `branch_taken` with target 0x43 while fetch at 0x20 is pending (ready=0 for 2 more cycles): 0x20 data is never in IF/ID. Next request is to 0x40.
- `branch_taken`, stall=1 and `imem_ready`=1 in the same cycle, target 0x100: next cycle `if_id_valid`=0, `imem_addr`=0x100, state FETCH.
- `rst_n` low for one cycle while in HOLD: all outputs return to reset values and fetch restarts at RESET_PC. Also cover ADDR_W=8 with pc=0xFC: next fetch is 0x00.
